// File: rtl/fir_cfg_master_if.sv
// AXI-Lite initiator bundle: write address, write data, read address
// and read data channels (no write-response channel on this slave).
interface fir_cfg_master_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);

    logic                   awvalid;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   awready;
    logic                   wvalid;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   wready;
    logic                   arvalid;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   arready;
    logic                   rvalid;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata,
        output arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata,
        input  arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );

endinterface

// File: rtl/fir_cfg_master.sv
// FIR coefficient configuration master: writes every tap over AXI-Lite,
// reads each back and compares, then pulses stream_start_send.
module fir_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int Start_Delay = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   coef_we,
    input  logic [3:0]             coef_idx,
    input  logic [pDATA_WIDTH-1:0] coef_wdata,
    input  logic                   cfg_start,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic [3:0]             err_cnt,
    output logic                   stream_start_send,
    fir_cfg_master_if.master       axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_A,
        S_RD_D,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [3:0] C_LAST = 4'(Tape_Num - 1);
    localparam logic [4:0] C_NUM  = 5'(Tape_Num);
    // FIN lands Start_Delay cycles after the last readback cycle
    // (WAIT_START spans Start_Delay-1 cycles; minimum of one).
    localparam int         C_DLY_I    = (Start_Delay > 1) ? Start_Delay - 2 : 0;
    localparam logic [7:0] C_DLY_LAST = 8'(C_DLY_I);

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_idx;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic [7:0]             r_dly;
    logic                   r_err;
    logic [3:0]             r_err_cnt;
    logic [pDATA_WIDTH-1:0] r_coef [Tape_Num];

    logic                   w_awv;
    logic                   w_wv;
    logic                   w_arv;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_wr_both;
    logic                   w_last;
    logic                   w_mis;
    logic [pDATA_WIDTH-1:0] w_tap;
    logic [pADDR_WIDTH-1:0] w_addr;

    assign w_tap     = r_coef[r_idx];
    assign w_addr    = pADDR_WIDTH'({r_idx, 2'b00});
    assign w_last    = (r_idx == C_LAST);
    assign w_awv     = (r_state == S_WR) & ~r_aw_done;
    assign w_wv      = (r_state == S_WR) & ~r_w_done;
    assign w_arv     = (r_state == S_RD_A);
    assign w_aw_hs   = w_awv & axi.awready;
    assign w_w_hs    = w_wv & axi.wready;
    assign w_ar_hs   = w_arv & axi.arready;
    assign w_r_hs    = (r_state == S_RD_D) & axi.rvalid;
    assign w_wr_both = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_mis     = w_r_hs & (axi.rdata != w_tap);

    assign axi.awvalid = w_awv;
    assign axi.awaddr  = w_awv ? w_addr : '0;
    assign axi.wvalid  = w_wv;
    assign axi.wdata   = w_wv ? w_tap : '0;
    assign axi.arvalid = w_arv;
    assign axi.araddr  = w_arv ? w_addr : '0;
    assign axi.rready  = (r_state == S_RD_D);

    assign cfg_busy          = (r_state != S_IDLE);
    assign cfg_done          = (r_state == S_FIN);
    assign stream_start_send = (r_state == S_FIN) & (r_err_cnt == 4'd0);
    assign cfg_error         = r_err;
    assign err_cnt           = r_err_cnt;

    // State register
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode for the write / readback / launch sequence
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (cfg_start) w_next = S_WR;
            S_WR:   if (w_wr_both && w_last) w_next = S_RD_A;
            S_RD_A: if (w_ar_hs) w_next = S_RD_D;
            S_RD_D: if (axi.rvalid) w_next = w_last ? S_WAIT : S_RD_A;
            S_WAIT: if (r_dly == C_DLY_LAST) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Tap index, per-channel write done flags, delay and error tracking
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_idx     <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_dly     <= 8'd0;
            r_err     <= 1'b0;
            r_err_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_idx     <= 4'd0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_err     <= 1'b0;
                        r_err_cnt <= 4'd0;
                    end
                end
                S_WR: begin
                    if (w_wr_both) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_idx     <= w_last ? 4'd0 : r_idx + 4'd1;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                S_RD_D: begin
                    if (w_r_hs) begin
                        if (w_mis) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 4'hF) r_err_cnt <= r_err_cnt + 4'd1;
                        end
                        r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
                        r_dly <= 8'd0;
                    end
                end
                S_WAIT: r_dly <= r_dly + 8'd1;
                default: ;
            endcase
        end
    end

    // Coefficient table, host-writable only while idle
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < Tape_Num; i++) r_coef[i] <= '0;
        end else if (r_state == S_IDLE && coef_we && {1'b0, coef_idx} < C_NUM) begin
            r_coef[coef_idx] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master: AXI-Lite slave model with
// configurable stalls and corruption, immediate-assertion checks.
module tb_fir_cfg_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coef_we = 1'b0;
    logic [3:0]    coef_idx = 4'd0;
    logic [DW-1:0] coef_wdata = '0;
    logic          cfg_start = 1'b0;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_error;
    logic [3:0]    err_cnt;
    logic          stream_start_send;

    always #5 clk = ~clk;

    fir_cfg_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axi ();

    fir_cfg_master #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .Tape_Num(NT),
        .Start_Delay(SD)
    ) dut (
        .axis_clk(clk),
        .axis_rst_n(rst_n),
        .coef_we(coef_we),
        .coef_idx(coef_idx),
        .coef_wdata(coef_wdata),
        .cfg_start(cfg_start),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .cfg_error(cfg_error),
        .err_cnt(err_cnt),
        .stream_start_send(stream_start_send),
        .axi(axi)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] t1 [NT] = '{32'h0, 32'hFFFFFFF6, 32'hFFFFFFF7, 32'h17,
                               32'h38, 32'h3F, 32'h38, 32'h17,
                               32'hFFFFFFF7, 32'hFFFFFFF6, 32'h0};
    logic [DW-1:0] t2 [NT];
    logic [DW-1:0] mem [16];

    bit aw_slow = 0;
    bit rv_hold = 0;
    bit corrupt = 0;

    int cyc = 0;
    int aw_wait = 0;
    bit rd_pend = 0;
    int rd_wait = 0;
    int rd_idx = 0;
    int aw_cnt = 0;
    int ar_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int ss_cnt = 0;
    int hold_cyc = 0;
    int first_aw = 0;
    int last_aw = -10;
    int last_rv = 0;
    int exp_idx = 0;
    bit aw_pend_prev = 0;
    bit w_early = 0;
    logic [AW-1:0] aw_prev = '0;
    logic [AW-1:0] awq [$];
    logic [DW-1:0] wq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdval(input int i);
        logic [3:0] a;
        a = i[3:0];
        if (corrupt && i == 5) return 32'd62;
        if (corrupt && i == 9) return mem[a] ^ 32'd1;
        return mem[a];
    endfunction

    // Slave model and protocol monitor, all on the falling edge
    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit aw_hs;
        bit w_hs;
        cyc++;
        if (!rst_n) begin
            rd_pend = 0;
            aw_wait = 0;
            awq.delete();
            wq.delete();
            exp_idx = 0;
            aw_pend_prev = 0;
            w_early = 0;
            axi.awready = 0;
            axi.wready = 0;
            axi.arready = 0;
            axi.rvalid = 0;
            axi.rdata = '0;
        end else begin
            if (aw_pend_prev) chk("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, aw_prev});
            if (w_early) chk("w_drop", axi.wvalid, 0);
            if (axi.awvalid) chk("aw_ar_excl", axi.arvalid, 0);
            axi.awready = !aw_slow || axi.awaddr[2] || aw_wait >= 3;
            axi.wready = 1;
            axi.arready = 1;
            axi.rvalid = rd_pend && rd_wait >= ((rv_hold && rd_idx == 0) ? 10 : 0);
            axi.rdata = axi.rvalid ? rdval(rd_idx) : '0;
            if (rd_pend && !axi.rvalid) begin
                hold_cyc++;
                chk("hold_ch", {axi.rready, axi.awvalid, axi.wvalid, axi.arvalid}, 4'b1000);
            end
            if (axi.rvalid && axi.rready) begin
                rd_pend = 0;
                last_rv = cyc;
            end else if (rd_pend) begin
                rd_wait++;
            end
            if (axi.arvalid && axi.arready) begin
                rd_pend = 1;
                rd_wait = 0;
                rd_idx = int'(axi.araddr >> 2);
                ar_cnt++;
            end
            aw_hs = axi.awvalid && axi.awready;
            w_hs = axi.wvalid && axi.wready;
            if (aw_hs) begin
                awq.push_back(axi.awaddr);
                aw_wait = 0;
                if (cyc != last_aw + 1) first_aw = cyc;
                last_aw = cyc;
                aw_cnt++;
            end else if (axi.awvalid) begin
                aw_wait++;
            end
            aw_pend_prev = axi.awvalid && !axi.awready;
            aw_prev = axi.awaddr;
            if (w_hs) wq.push_back(axi.wdata);
            if (w_hs && !aw_hs) w_early = 1;
            else if (aw_hs) w_early = 0;
            while (awq.size() > 0 && wq.size() > 0) begin
                a = awq.pop_front();
                d = wq.pop_front();
                chk("wr_order", a, AW'(exp_idx * 4));
                mem[a[5:2]] = d;
                exp_idx = (exp_idx == NT - 1) ? 0 : exp_idx + 1;
                wr_cnt++;
            end
            if (cfg_done) done_cnt++;
            if (stream_start_send) begin
                ss_cnt++;
                chk("ss_delay", cyc - last_rv, SD);
                chk("ss_with_done", cfg_done, 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input bit second);
        for (int i = 0; i < NT; i++) begin
            coef_we = 1;
            coef_idx = 4'(i);
            coef_wdata = second ? t2[i] : t1[i];
            tick(1);
        end
        coef_we = 0;
    endtask

    task automatic start();
        cfg_start = 1;
        tick(1);
        cfg_start = 0;
    endtask

    task automatic run_wait(input string tag, input int budget);
        for (int i = 0; i < budget && !cfg_done; i++) tick(1);
        chk({tag, "_done"}, cfg_done, 1);
    endtask

    function automatic int mem_diff(input bit second);
        int m = 0;
        for (int i = 0; i < NT; i++) begin
            if (mem[i] !== (second ? t2[i] : t1[i])) m++;
        end
        return m;
    endfunction

    initial begin
        int a0, r0, s0, d0, w0, h0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < NT; i++) t2[i] = DW'(i * 7 + 1);
        tick(2);
        chk("rst_outs", {cfg_busy, cfg_done, cfg_error, err_cnt, stream_start_send,
                         axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 0);
        rst_n = 1;
        tick(1);
        chk("idle_busy", cfg_busy, 0);

        // Nominal run with the symmetric low-pass taps
        load(0);
        a0 = aw_cnt; r0 = ar_cnt; s0 = ss_cnt;
        start();
        chk("t1_busy", cfg_busy, 1);
        run_wait("t1", 200);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_cfg_error", cfg_error, 0);
        chk("t1_ss", stream_start_send, 1);
        chk("t1_aw_cnt", aw_cnt - a0, 11);
        chk("t1_ar_cnt", ar_cnt - r0, 11);
        chk("t1_aw_burst", last_aw - first_aw + 1, 11);
        chk("t1_ss_cnt", ss_cnt - s0, 1);
        chk("t1_mem", mem_diff(0), 0);
        tick(1);
        chk("t1_idle", {cfg_busy, stream_start_send, cfg_done}, 0);

        // Slow awready on even taps, immediate wready
        aw_slow = 1;
        load(1);
        w0 = wr_cnt;
        start();
        run_wait("t2", 400);
        aw_slow = 0;
        chk("t2_err_cnt", err_cnt, 0);
        chk("t2_ss", stream_start_send, 1);
        chk("t2_wr_cnt", wr_cnt - w0, 11);
        chk("t2_mem", mem_diff(1), 0);
        tick(1);

        // Corrupted readback on taps 5 and 9
        load(0);
        corrupt = 1;
        s0 = ss_cnt;
        start();
        run_wait("t3", 200);
        corrupt = 0;
        chk("t3_err_cnt", err_cnt, 2);
        chk("t3_cfg_error", cfg_error, 1);
        chk("t3_ss", stream_start_send, 0);
        tick(1);
        chk("t3_ss_cnt", ss_cnt - s0, 0);
        chk("t3_err_sticky", cfg_error, 1);

        // Host pulses during a sequence are ignored
        a0 = aw_cnt; r0 = ar_cnt; d0 = done_cnt;
        start();
        chk("t4_err_clr", {cfg_error, err_cnt}, 0);
        coef_we = 1;
        coef_idx = 4'd3;
        coef_wdata = 32'd999;
        cfg_start = 1;
        tick(1);
        coef_we = 0;
        cfg_start = 0;
        tick(14);
        cfg_start = 1;
        tick(1);
        cfg_start = 0;
        run_wait("t4", 200);
        chk("t4_err_cnt", err_cnt, 0);
        chk("t4_ss", stream_start_send, 1);
        chk("t4_mem3", mem[3], t1[3]);
        tick(3);
        chk("t4_axi_cnt", (aw_cnt - a0) + (ar_cnt - r0), 22);
        chk("t4_done_cnt", done_cnt - d0, 1);
        chk("t4_no_restart", cfg_busy, 0);

        // Asynchronous reset during readback
        start();
        for (int i = 0; i < 100 && !axi.rready; i++) tick(1);
        chk("t5_in_rd_d", axi.rready, 1);
        #2;
        rst_n = 0;
        #1;
        chk("t5_rst_ctl", {cfg_busy, cfg_done, cfg_error, err_cnt, stream_start_send,
                           axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 0);
        chk("t5_rst_bus", {axi.awaddr, axi.araddr, axi.wdata}, 0);
        tick(2);
        rst_n = 1;
        tick(1);
        start();
        run_wait("t5_clr", 200);
        chk("t5_clr_err", err_cnt, 0);
        chk("t5_clr_mem5", mem[5], 0);
        tick(1);
        load(0);
        start();
        run_wait("t5", 200);
        chk("t5_err_cnt", err_cnt, 0);
        chk("t5_ss", stream_start_send, 1);
        chk("t5_mem", mem_diff(0), 0);
        tick(1);

        // rvalid withheld on tap 0
        rv_hold = 1;
        h0 = hold_cyc; r0 = ar_cnt;
        start();
        run_wait("t6", 300);
        rv_hold = 0;
        chk("t6_hold", hold_cyc - h0, 10);
        chk("t6_ar_cnt", ar_cnt - r0, 11);
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_ss", stream_start_send, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
